// File: rtl/serial_link_pkg.sv
// Shared types and defaults for the bit-serial byte link (transmit and receive sides).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   tx_state_t          transmitter FSM state encoding
//   DEF_DATA_W          default bits per transfer
//   DEF_HIGH_CYCLES     default strobe-high cycles per bit
//   DEF_LOW_CYCLES      default strobe-low cycles per bit
//   max_int()           elaboration-time helper for sizing counters
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STAT,
        HIGH,
        LOW,
        END_BYTE
    } tx_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_HIGH_CYCLES = 10;
    localparam int DEF_LOW_CYCLES  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: load a cycle count, get a one-cycle expire in the last cycle of the phase.
// Latency: expire is high in the Nth cycle after the start edge for load_val=N (N>=1).
// Backpressure: none; a start in the expire cycle chains the next phase with no gap.
//
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset, clears the count
//   start     in   1      load load_val on this edge (overrides counting)
//   load_val  in   CNT_W  phase length in cycles
//   expire    out  1      high during the final cycle of the loaded phase
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count runs down to zero and parks there; zero means "not running",
    // so an idle timer can never produce a spurious expire.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 marks the last cycle of the phase.
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/serial_byte_tx.sv
// Bit-serial byte transmitter: takes a byte on valid/ready, waits for status_in, shifts it out LSB-first with a write strobe per bit.
// Latency: write_out rises on the edge after the WAIT_STAT->HIGH decision; byte = DATA_W*(HIGH_CYCLES+LOW_CYCLES) cycles + END_BYTE.
// Backpressure: tx_ready_out is high only in IDLE; the caller holds tx_valid_in/tx_data_in until accepted.
//
// Ports:
//   clock_1MHz    in   1       system clock, rising edge
//   rst           in   1       synchronous active-high reset; aborts any byte in flight
//   tx_valid_in   in   1       tx_data_in holds a byte to send
//   tx_data_in    in   DATA_W  byte to send, captured on accept
//   tx_ready_out  out  1       block can accept a byte
//   status_in     in   1       receiver ready-for-byte level
//   data_out      out  1       serial data, LSB first
//   write_out     out  1       bit-qualifying strobe
//   busy_out      out  1       high in every state except IDLE
//   done_out      out  1       one-cycle pulse when a byte completes
//
// Build option: define STATUS_DROP_WAIT_EN to make END_BYTE wait for status_in
// to fall before returning to IDLE, so a byte is never resent into the same
// receiver status window.
module serial_byte_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int LOW_CYCLES  = DEF_LOW_CYCLES
) (
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              tx_valid_in,
    input  logic [DATA_W-1:0] tx_data_in,
    output logic              tx_ready_out,
    input  logic              status_in,
    output logic              data_out,
    output logic              write_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int MAX_CYC = max_int(HIGH_CYCLES, LOW_CYCLES);
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

    logic tx_ready_q, tx_ready_d;
    logic data_q, data_d;
    logic write_q, write_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic             tmr_start;
    logic [TMR_W-1:0] tmr_load;
    logic             tmr_expire;

    phase_timer #(
        .CNT_W (TMR_W)
    ) u_phase_timer (
        .clk      (clock_1MHz),
        .rst      (rst),
        .start    (tmr_start),
        .load_val (tmr_load),
        .expire   (tmr_expire)
    );

    // Next-state logic. The timer is (re)started on every edge that enters
    // HIGH or LOW, so each phase lasts exactly its configured cycle count.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tmr_start = 1'b0;
        tmr_load  = '0;

        case (state_q)
            IDLE: begin
                // tx_ready_out is high exactly in IDLE, so tx_valid_in alone
                // completes the handshake here.
                if (tx_valid_in) begin
                    state_d   = WAIT_STAT;
                    shreg_d   = tx_data_in;
                    bit_idx_d = '0;
                end
            end

            WAIT_STAT: begin
                if (status_in) begin
                    state_d   = HIGH;
                    tmr_start = 1'b1;
                    tmr_load  = HIGH_LOAD;
                end
            end

            HIGH: begin
                if (tmr_expire) begin
                    state_d   = LOW;
                    tmr_start = 1'b1;
                    tmr_load  = LOW_LOAD;
                end
            end

            LOW: begin
                if (tmr_expire) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        // Index returns to zero rather than wrapping past the last bit.
                        state_d   = END_BYTE;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = HIGH;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tmr_start = 1'b1;
                        tmr_load  = HIGH_LOAD;
                    end
                end
            end

            END_BYTE: begin
`ifdef STATUS_DROP_WAIT_EN
                // Hold off completion until the receiver withdraws status,
                // otherwise the next byte could land in the same window.
                if (!status_in) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered Moore outputs, computed from the next state so each pin
    // changes on the same edge as the state register.
    always_comb begin
        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        write_d    = (state_d == HIGH);
        // Data is launched with the strobe and held through LOW; shreg_d
        // already holds the shifted value when LOW hands over to HIGH.
        data_d     = (state_d == HIGH) ? shreg_d[0] : data_q;
        done_d     = (state_q == END_BYTE) && (state_d == IDLE);
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            tx_ready_q <= 1'b1;
            data_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            tx_ready_q <= tx_ready_d;
            data_q     <= data_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready_out = tx_ready_q;
    assign data_out     = data_q;
    assign write_out    = write_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;

endmodule
